// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the 32x32 register file. Two requesters share the
// register file's single write port: A (ALU result) and B (load result).
// Each requester has a one-entry holding register. Pending writes issue
// oldest-first through a registered write port. Read-after-write hazards
// against the two decode-stage read addresses are flagged combinationally.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A write offer and handshake
//   b_valid/b_ready/b_addr/b_data   requester B write offer and handshake
//   chk_en, chk_addrA, chk_addrB    decode-stage read enable and addresses
//   rf_memread                passthrough of chk_en to the register file
//   rf_memwrite, rf_addrWR, rf_write_data   registered write port
//   hazard                    a held, not-yet-issued write targets a read address
//   wr_count                  number of writes issued, wraps

module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_addr,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [31:0]      b_data,
  input  logic             chk_en,
  input  logic [4:0]       chk_addrA,
  input  logic [4:0]       chk_addrB,
  output logic             rf_memread,
  output logic             rf_memwrite,
  output logic [4:0]       rf_addrWR,
  output logic [31:0]      rf_write_data,
  output logic             hazard,
  output logic [CNT_W-1:0] wr_count
);

  typedef struct packed {
    logic        full;
    logic [4:0]  addr;
    logic [31:0] data;
  } hold_t;

  hold_t hold_a;
  hold_t hold_b;
  logic  b_older;
  logic  grant_a;
  logic  grant_b;
  logic  a_accept;
  logic  b_accept;
  logic  hit_a;
  logic  hit_b;

  // Oldest-first grant: a lone full entry always wins; with both full the
  // age bit decides.
  always_comb begin
    grant_a = hold_a.full & (~hold_b.full | ~b_older);
    grant_b = hold_b.full & (~hold_a.full | b_older);
  end

  // A granted entry is vacated on this edge, so it can be refilled at once;
  // this is what keeps a lone streaming requester at full throughput.
  assign a_ready  = ~hold_a.full | grant_a;
  assign b_ready  = ~hold_b.full | grant_b;
  assign a_accept = a_valid & a_ready;
  assign b_accept = b_valid & b_ready;

  assign rf_memread = chk_en;

  // Only held entries matter: the output register's write lands at the
  // falling edge and is visible to the combinational read in the same cycle.
  assign hit_a  = hold_a.full & ((hold_a.addr == chk_addrA) | (hold_a.addr == chk_addrB));
  assign hit_b  = hold_b.full & ((hold_b.addr == chk_addrA) | (hold_b.addr == chk_addrB));
  assign hazard = chk_en & (hit_a | hit_b);

  // Holding registers and age tracking. A newly accepted write is always
  // the youngest; a simultaneous pair treats A as the older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a  <= '0;
      hold_b  <= '0;
      b_older <= 1'b0;
    end else begin
      if (a_accept) begin
        hold_a <= '{full: 1'b1, addr: a_addr, data: a_data};
      end else if (grant_a) begin
        hold_a.full <= 1'b0;
      end

      if (b_accept) begin
        hold_b <= '{full: 1'b1, addr: b_addr, data: b_data};
      end else if (grant_b) begin
        hold_b.full <= 1'b0;
      end

      // B is older only if it is still held after this edge while A refills.
      if (a_accept && !b_accept) begin
        b_older <= hold_b.full & ~grant_b;
      end else if (b_accept) begin
        b_older <= 1'b0;
      end
    end
  end

  // Registered write port; address and data hold their last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_memwrite   <= 1'b0;
      rf_addrWR     <= '0;
      rf_write_data <= '0;
      wr_count      <= '0;
    end else begin
      if (grant_a) begin
        rf_memwrite   <= 1'b1;
        rf_addrWR     <= hold_a.addr;
        rf_write_data <= hold_a.data;
        wr_count      <= wr_count + 1'b1;
      end else if (grant_b) begin
        rf_memwrite   <= 1'b1;
        rf_addrWR     <= hold_b.addr;
        rf_write_data <= hold_b.data;
        wr_count      <= wr_count + 1'b1;
      end else begin
        rf_memwrite   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change at the falling
// edge; outputs are checked at the following falling edge, away from the
// rising edge where the DUT updates. A small register-file image records
// what the write port commits at each falling edge.

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        chk_en;
  logic [4:0]  chk_addrA;
  logic [4:0]  chk_addrB;
  logic        rf_memread;
  logic        rf_memwrite;
  logic [4:0]  rf_addrWR;
  logic [31:0] rf_write_data;
  logic        hazard;
  logic [15:0] wr_count;

  logic [31:0] rfImage [32];
  int          vecCount;
  int          missCount;

  regfile_wb_arbiter #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .chk_en        (chk_en),
    .chk_addrA     (chk_addrA),
    .chk_addrB     (chk_addrB),
    .rf_memread    (rf_memread),
    .rf_memwrite   (rf_memwrite),
    .rf_addrWR     (rf_addrWR),
    .rf_write_data (rf_write_data),
    .hazard        (hazard),
    .wr_count      (wr_count)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file behaviour: writes commit at the falling edge.
  always @(negedge clk) begin
    if (rf_memwrite) rfImage[rf_addrWR] <= rf_write_data;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests from a falling edge to the next falling edge.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    for (int i = 0; i < 32; i++) rfImage[i] = 32'd0;
    rst       = 1'b1;
    a_valid   = 1'b0;
    a_addr    = 5'd0;
    a_data    = 32'd0;
    b_valid   = 1'b0;
    b_addr    = 5'd0;
    b_data    = 32'd0;
    chk_en    = 1'b0;
    chk_addrA = 5'd0;
    chk_addrB = 5'd0;

    // Reset state and memread passthrough during reset
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    checkOutput("memread_in_reset", 32'(rf_memread), 32'd1);
    checkOutput("memwrite_in_reset", 32'(rf_memwrite), 32'd0);
    chk_en = 1'b0;
    #1;
    checkOutput("memread_low", 32'(rf_memread), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    checkOutput("rst_memwrite", 32'(rf_memwrite), 32'd0);
    checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
    checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
    checkOutput("rst_hazard", 32'(hazard), 32'd0);
    checkOutput("rst_addr", 32'(rf_addrWR), 32'd0);
    checkOutput("rst_data", rf_write_data, 32'd0);
    chk_en = 1'b0;
    idleCycle();
    idleCycle();
    checkOutput("idle_memwrite", 32'(rf_memwrite), 32'd0);
    checkOutput("idle_wr_count", 32'(wr_count), 32'd0);

    // A alone writes r5 = 0xAA
    applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    checkOutput("a_held_no_issue", 32'(rf_memwrite), 32'd0);
    chk_en = 1'b1; chk_addrA = 5'd5; chk_addrB = 5'd9;
    #1;
    checkOutput("hazard_a_r5", 32'(hazard), 32'd1);
    idleCycle();
    checkOutput("a_issue_we", 32'(rf_memwrite), 32'd1);
    checkOutput("a_issue_addr", 32'(rf_addrWR), 32'd5);
    checkOutput("a_issue_data", rf_write_data, 32'h0000_00AA);
    checkOutput("a_issue_count", 32'(wr_count), 32'd1);
    checkOutput("a_issue_hazard", 32'(hazard), 32'd0);
    chk_en = 1'b0;
    idleCycle();
    checkOutput("a_done_we", 32'(rf_memwrite), 32'd0);
    checkOutput("a_done_addr_kept", 32'(rf_addrWR), 32'd5);
    checkOutput("a_done_data_kept", rf_write_data, 32'h0000_00AA);
    checkOutput("rf_r5", rfImage[5], 32'h0000_00AA);

    // A and B at the same edge to r3: A first, then B
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    checkOutput("pair_no_issue", 32'(rf_memwrite), 32'd0);
    checkOutput("pair_a_ready", 32'(a_ready), 32'd1);
    checkOutput("pair_b_ready", 32'(b_ready), 32'd0);
    idleCycle();
    checkOutput("pair1_addr", 32'(rf_addrWR), 32'd3);
    checkOutput("pair1_data", rf_write_data, 32'h11);
    checkOutput("pair1_count", 32'(wr_count), 32'd2);
    checkOutput("pair1_b_ready", 32'(b_ready), 32'd1);
    idleCycle();
    checkOutput("pair2_we", 32'(rf_memwrite), 32'd1);
    checkOutput("pair2_data", rf_write_data, 32'h22);
    checkOutput("pair2_count", 32'(wr_count), 32'd3);
    idleCycle();
    checkOutput("pair_done_we", 32'(rf_memwrite), 32'd0);
    checkOutput("rf_r3", rfImage[3], 32'h22);

    // B at N, A at N+1: B issues first, A ready throughout
    checkOutput("ba_ready0", 32'(a_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    checkOutput("ba_ready1", 32'(a_ready), 32'd1);
    applyStimulus(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'd0);
    checkOutput("ba_b_addr", 32'(rf_addrWR), 32'd9);
    checkOutput("ba_b_data", rf_write_data, 32'h99);
    checkOutput("ba_ready2", 32'(a_ready), 32'd1);
    idleCycle();
    checkOutput("ba_a_addr", 32'(rf_addrWR), 32'd10);
    checkOutput("ba_a_data", rf_write_data, 32'h100);
    checkOutput("ba_count", 32'(wr_count), 32'd5);
    idleCycle();

    // A refilled while B waits: B becomes older and goes next
    applyStimulus(1'b1, 5'd11, 32'h111, 1'b1, 5'd12, 32'h222);
    applyStimulus(1'b1, 5'd13, 32'h333, 1'b0, 5'd0, 32'd0);
    checkOutput("age1_addr", 32'(rf_addrWR), 32'd11);
    checkOutput("age1_count", 32'(wr_count), 32'd6);
    checkOutput("age1_a_ready", 32'(a_ready), 32'd0);
    checkOutput("age1_b_ready", 32'(b_ready), 32'd1);
    idleCycle();
    checkOutput("age2_addr", 32'(rf_addrWR), 32'd12);
    checkOutput("age2_data", rf_write_data, 32'h222);
    checkOutput("age2_a_ready", 32'(a_ready), 32'd1);
    idleCycle();
    checkOutput("age3_addr", 32'(rf_addrWR), 32'd13);
    checkOutput("age3_data", rf_write_data, 32'h333);
    checkOutput("age3_count", 32'(wr_count), 32'd8);
    idleCycle();
    checkOutput("age_done_we", 32'(rf_memwrite), 32'd0);

    // Hazard on a held B write to r7
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    chk_en = 1'b1; chk_addrA = 5'd7; chk_addrB = 5'd20;
    #1;
    checkOutput("hz_addrA_r7", 32'(hazard), 32'd1);
    chk_addrA = 5'd8;
    #1;
    checkOutput("hz_addrA_r8", 32'(hazard), 32'd0);
    chk_addrA = 5'd20; chk_addrB = 5'd7;
    #1;
    checkOutput("hz_addrB_r7", 32'(hazard), 32'd1);
    chk_en = 1'b0;
    #1;
    checkOutput("hz_chk_off", 32'(hazard), 32'd0);
    chk_en = 1'b1; chk_addrA = 5'd7;
    idleCycle();
    checkOutput("hz_issue_we", 32'(rf_memwrite), 32'd1);
    checkOutput("hz_issue_addr", 32'(rf_addrWR), 32'd7);
    checkOutput("hz_cleared", 32'(hazard), 32'd0);
    checkOutput("hz_count", 32'(wr_count), 32'd9);
    chk_en = 1'b0;

    // Register 0 is an ordinary target
    applyStimulus(1'b1, 5'd0, 32'h5A, 1'b0, 5'd0, 32'd0);
    chk_en = 1'b1; chk_addrA = 5'd3; chk_addrB = 5'd0;
    #1;
    checkOutput("hz_r0", 32'(hazard), 32'd1);
    chk_en = 1'b0;
    idleCycle();
    checkOutput("r0_addr", 32'(rf_addrWR), 32'd0);
    checkOutput("r0_data", rf_write_data, 32'h5A);
    checkOutput("r0_count", 32'(wr_count), 32'd10);
    idleCycle();

    // A streams back-to-back with B idle
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_ready", 32'(a_ready), 32'd1);
      applyStimulus(1'b1, 5'(16 + i), 32'(i + 1), 1'b0, 5'd0, 32'd0);
      if (i > 0) begin
        checkOutput("stream_we", 32'(rf_memwrite), 32'd1);
        checkOutput("stream_addr", 32'(rf_addrWR), 32'(15 + i));
        checkOutput("stream_data", rf_write_data, 32'(i));
      end
    end
    idleCycle();
    checkOutput("stream_last_addr", 32'(rf_addrWR), 32'd19);
    checkOutput("stream_count", 32'(wr_count), 32'd14);
    idleCycle();
    checkOutput("rf_r18", rfImage[18], 32'd3);

    // Reset rising while a write is on the port aborts it
    applyStimulus(1'b1, 5'd21, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_we_before", 32'(rf_memwrite), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_we_cleared", 32'(rf_memwrite), 32'd0);
    checkOutput("abort_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("abort_rf_r21", rfImage[21], 32'd0);
    rst = 1'b0;
    idleCycle();

    // Fill both entries, then reset before any issue
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("fill_rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("fill_rst_b_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    checkOutput("fill_rst_we", 32'(rf_memwrite), 32'd0);
    rst = 1'b0;
    idleCycle();
    checkOutput("post_rst_we", 32'(rf_memwrite), 32'd0);
    checkOutput("post_rst_count", 32'(wr_count), 32'd0);
    checkOutput("post_rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("post_rst_b_ready", 32'(b_ready), 32'd1);
    idleCycle();
    checkOutput("post_rst_we2", 32'(rf_memwrite), 32'd0);
    checkOutput("rf_r1_untouched", rfImage[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
